// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// register-select decode and the ID-to-onehot helper.
package irq_ctrl_pkg;

  localparam int ID_W = 5;

  localparam logic [31:0] ADDR_PENDING   = 32'h0000_0000;
  localparam logic [31:0] ADDR_ENABLE    = 32'h0000_0004;
  localparam logic [31:0] ADDR_EDGE      = 32'h0000_0008;
  localparam logic [31:0] ADDR_CLAIM     = 32'h0000_000C;
  localparam logic [31:0] ADDR_INSERVICE = 32'h0000_0010;

  typedef enum logic [2:0] {
    REG_PENDING,
    REG_ENABLE,
    REG_EDGE,
    REG_CLAIM,
    REG_INSERVICE,
    REG_NONE
  } reg_sel_e;

  // Word index (byte address bits [31:2]) to register select.
  function automatic reg_sel_e decode_addr(input logic [29:0] widx);
    case (widx)
      ADDR_PENDING[31:2]:   return REG_PENDING;
      ADDR_ENABLE[31:2]:    return REG_ENABLE;
      ADDR_EDGE[31:2]:      return REG_EDGE;
      ADDR_CLAIM[31:2]:     return REG_CLAIM;
      ADDR_INSERVICE[31:2]: return REG_INSERVICE;
      default:              return REG_NONE;
    endcase
  endfunction

  // ID n (1-based) maps to bit n-1; ID 0 maps to no bit.
  function automatic logic [31:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [31:0] oh;
    oh = '0;
    if (id != '0) oh[id - ID_W'(1)] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority find-first-set: the lowest set request index wins.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    // Walk from the top down so the last hit, the lowest index, sticks.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source enable, edge/level pending, fixed-priority
// claim/complete, programmed over the shared c_* configuration bus.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int SYNC = 2
) (
  input  logic            c_clk,
  input  logic            c_rstb,
  input  logic [NSRC-1:0] src,
  output logic            irq_out,
  output logic            c_ready,
  output logic [31:0]     c_rdata,
  input  logic [31:0]     c_wdata,
  input  logic            c_write,
  input  logic [31:0]     c_addr,
  input  logic [1:0]      c_size,
  input  logic            c_valid
);

  logic [NSRC-1:0] s, s_d;
  logic [NSRC-1:0] enable_q, edge_q, inservice_q, pend_edge_q, pend_edge_d;
  logic [NSRC-1:0] pending, eligible, w1c_clr, edge_chg, claim_oh, cmp_clr;
  logic [31:0]     claim_oh32, cmp_oh32, wdata_sh, rd_word;
  logic [4:0]      sh;
  logic            acc, claim_fire, cmp_fire, win_valid;
  logic [ID_W-1:0] win_idx;
  reg_sel_e        sel;
  logic            unused_size;

  // Byte lanes come from c_addr[1:0]; the size field carries no information.
  assign unused_size = ^c_size;

  for (genvar i = 0; i < NSRC; i++) begin : g_sync
    logic [SYNC-1:0] chain;
    always_ff @(posedge c_clk or negedge c_rstb) begin
      if (!c_rstb) chain <= '0;
      else         chain <= {chain[SYNC-2:0], src[i]};
    end
    assign s[i] = chain[SYNC-1];
  end

  assign acc      = c_valid & ~c_ready;
  assign sel      = decode_addr(c_addr[31:2]);
  assign sh       = {c_addr[1:0], 3'b000};
  assign wdata_sh = c_wdata << sh;

  assign pending  = (pend_edge_q & edge_q) | (s & ~edge_q);
  assign eligible = pending & enable_q & ~inservice_q;

  irq_prio_enc #(.N(NSRC)) u_prio (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  assign claim_fire = acc & ~c_write & (sel == REG_CLAIM) & win_valid;
  assign claim_oh32 = id_to_onehot(win_idx + ID_W'(1));
  assign claim_oh   = claim_fire ? claim_oh32[NSRC-1:0] : '0;

  // The whole shifted word is range-checked so aliases like 0x21 never complete ID 1.
  assign cmp_fire = acc & c_write & (sel == REG_CLAIM)
                  & (wdata_sh >= 32'd1) & (wdata_sh <= 32'(NSRC));
  assign cmp_oh32 = id_to_onehot(wdata_sh[ID_W-1:0]);
  assign cmp_clr  = cmp_fire ? (cmp_oh32[NSRC-1:0] & inservice_q) : '0;

  assign w1c_clr  = (acc & c_write & (sel == REG_PENDING)) ? wdata_sh[NSRC-1:0] : '0;
  assign edge_chg = (acc & c_write & (sel == REG_EDGE))
                  ? (wdata_sh[NSRC-1:0] ^ edge_q) : '0;

  // A new edge is ORed in after the clears so it is never lost.
  assign pend_edge_d = (pend_edge_q & ~(w1c_clr | claim_oh | edge_chg))
                     | (s & ~s_d & edge_q);

  always_comb begin
    rd_word = '0;
    case (sel)
      REG_PENDING:   rd_word = 32'(pending);
      REG_ENABLE:    rd_word = 32'(enable_q);
      REG_EDGE:      rd_word = 32'(edge_q);
      REG_CLAIM:     rd_word = win_valid ? (32'(win_idx) + 32'd1) : 32'd0;
      REG_INSERVICE: rd_word = 32'(inservice_q);
      default:       rd_word = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb) begin
      s_d         <= '0;
      enable_q    <= '0;
      edge_q      <= '0;
      inservice_q <= '0;
      pend_edge_q <= '0;
      irq_out     <= 1'b0;
      c_ready     <= 1'b0;
      c_rdata     <= '0;
    end else begin
      s_d         <= s;
      pend_edge_q <= pend_edge_d;
      inservice_q <= (inservice_q | claim_oh) & ~cmp_clr;
      irq_out     <= |eligible;
      c_ready     <= c_valid;
      if (acc && c_write) begin
        case (sel)
          REG_ENABLE: enable_q <= wdata_sh[NSRC-1:0];
          REG_EDGE:   edge_q   <= wdata_sh[NSRC-1:0];
          default:    ;
        endcase
      end
      if (acc && !c_write) c_rdata <= rd_word >> sh;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (NSRC=16 so a 0xA500 ENABLE
// value is representable; IDs above 16 are out of range).
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int NSRC = 16;

  logic            c_clk = 1'b0;
  logic            c_rstb;
  logic [NSRC-1:0] src;
  logic            irq_out, c_ready;
  logic [31:0]     c_rdata, c_wdata, c_addr;
  logic            c_write, c_valid;
  logic [1:0]      c_size;
  logic [31:0]     rd;

  int n_tests = 0;
  int n_fail  = 0;

  irq_ctrl #(.NSRC(NSRC), .SYNC(2)) dut (
    .c_clk   (c_clk),
    .c_rstb  (c_rstb),
    .src     (src),
    .irq_out (irq_out),
    .c_ready (c_ready),
    .c_rdata (c_rdata),
    .c_wdata (c_wdata),
    .c_write (c_write),
    .c_addr  (c_addr),
    .c_size  (c_size),
    .c_valid (c_valid)
  );

  always #5 c_clk = ~c_clk;

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end just after a falling edge.
  task cyc(input int n);
    repeat (n) begin
      @(posedge c_clk);
      @(negedge c_clk);
    end
  endtask

  task bus_wr(input logic [31:0] addr, input logic [31:0] data);
    c_valid = 1'b1; c_write = 1'b1; c_addr = addr; c_wdata = data;
    @(posedge c_clk);
    @(negedge c_clk);
    c_valid = 1'b0; c_write = 1'b0;
    cyc(1);
  endtask

  task bus_rd(input logic [31:0] addr, output logic [31:0] data);
    c_valid = 1'b1; c_write = 1'b0; c_addr = addr;
    @(posedge c_clk);
    @(negedge c_clk);
    data = c_rdata;
    c_valid = 1'b0;
    cyc(1);
  endtask

  task rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(addr, d);
    check(tag, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    c_rstb = 1'b0; src = '0; c_wdata = '0; c_addr = '0;
    c_write = 1'b0; c_valid = 1'b0; c_size = 2'd2;
    repeat (2) @(negedge c_clk);
    check("rst_irq", 32'(irq_out), 32'd0);
    check("rst_ready", 32'(c_ready), 32'd0);
    check("rst_rdata", c_rdata, 32'd0);
    c_rstb = 1'b1;
    cyc(1);
    rd_chk("rst_pending", ADDR_PENDING, 32'h0);
    rd_chk("rst_enable", ADDR_ENABLE, 32'h0);
    rd_chk("rst_edge", ADDR_EDGE, 32'h0);
    rd_chk("rst_claim", ADDR_CLAIM, 32'h0);
    rd_chk("rst_inservice", ADDR_INSERVICE, 32'h0);

    // Edge source 0: single-cycle pulse sampled at E1, irq_out high after E4.
    bus_wr(ADDR_ENABLE, 32'h1);
    bus_wr(ADDR_EDGE, 32'h1);
    src[0] = 1'b1;
    @(posedge c_clk);
    @(negedge c_clk);
    src[0] = 1'b0;
    cyc(1);
    check("edge_irq_e2", 32'(irq_out), 32'd0);
    cyc(1);
    check("edge_irq_e3", 32'(irq_out), 32'd0);
    cyc(1);
    check("edge_irq_e4", 32'(irq_out), 32'd1);
    rd_chk("edge_pending", ADDR_PENDING, 32'h1);
    rd_chk("edge_claim", ADDR_CLAIM, 32'd1);
    check("edge_irq_after_claim", 32'(irq_out), 32'd0);
    rd_chk("edge_inservice", ADDR_INSERVICE, 32'h1);
    rd_chk("edge_pending_clr", ADDR_PENDING, 32'h0);
    bus_wr(ADDR_CLAIM, 32'd1);
    rd_chk("edge_complete", ADDR_INSERVICE, 32'h0);
    bus_wr(ADDR_EDGE, 32'h0);
    bus_wr(ADDR_ENABLE, 32'h0);

    // Level sources 1 and 2: priority, exhaustion, complete while still high.
    bus_wr(ADDR_ENABLE, 32'h6);
    src[2:1] = 2'b11;
    cyc(4);
    check("lvl_irq", 32'(irq_out), 32'd1);
    rd_chk("lvl_claim1", ADDR_CLAIM, 32'd2);
    rd_chk("lvl_claim2", ADDR_CLAIM, 32'd3);
    rd_chk("lvl_claim3", ADDR_CLAIM, 32'd0);
    check("lvl_irq_none", 32'(irq_out), 32'd0);
    bus_wr(ADDR_CLAIM, 32'd2);
    check("lvl_irq_reassert", 32'(irq_out), 32'd1);
    rd_chk("lvl_claim4", ADDR_CLAIM, 32'd2);
    bus_wr(ADDR_CLAIM, 32'd2);
    bus_wr(ADDR_CLAIM, 32'd3);
    src[2:1] = 2'b00;
    bus_wr(ADDR_ENABLE, 32'h0);
    rd_chk("lvl_inservice_done", ADDR_INSERVICE, 32'h0);

    // Edge source 3: the rise lands on the same edge as an accepted W1C.
    bus_wr(ADDR_ENABLE, 32'h8);
    bus_wr(ADDR_EDGE, 32'h8);
    src[3] = 1'b1;
    cyc(2);
    bus_wr(ADDR_PENDING, 32'h8);
    rd_chk("set_wins", ADDR_PENDING, 32'h8);
    bus_wr(ADDR_PENDING, 32'h8);
    rd_chk("w1c_clears", ADDR_PENDING, 32'h0);
    src[3] = 1'b0;
    bus_wr(ADDR_EDGE, 32'h0);
    bus_wr(ADDR_ENABLE, 32'h0);

    // Completes that must be ignored.
    bus_wr(ADDR_ENABLE, 32'h1);
    src[0] = 1'b1;
    cyc(4);
    rd_chk("inv_claim", ADDR_CLAIM, 32'd1);
    bus_wr(ADDR_CLAIM, 32'd0);
    rd_chk("cmp_id0", ADDR_INSERVICE, 32'h1);
    bus_wr(ADDR_CLAIM, 32'd17);
    rd_chk("cmp_id17", ADDR_INSERVICE, 32'h1);
    bus_wr(ADDR_CLAIM, 32'h21);
    rd_chk("cmp_id33", ADDR_INSERVICE, 32'h1);
    bus_wr(ADDR_CLAIM, 32'd2);
    rd_chk("cmp_not_insvc", ADDR_INSERVICE, 32'h1);
    bus_wr(ADDR_CLAIM, 32'd1);
    rd_chk("cmp_valid", ADDR_INSERVICE, 32'h0);
    src[0] = 1'b0;

    // Byte lanes and unimplemented bits.
    bus_wr(ADDR_ENABLE, 32'hFFFF_FFFF);
    rd_chk("enable_width", ADDR_ENABLE, 32'h0000_FFFF);
    bus_wr(ADDR_ENABLE, 32'h0000_A500);
    rd_chk("byte_rd_05", 32'h5, 32'h0000_00A5);
    bus_wr(32'h5, 32'h0000_003C);
    rd_chk("byte_wr_05", ADDR_ENABLE, 32'h0000_3C00);
    rd_chk("unmapped_rd", 32'h14, 32'h0);
    bus_wr(ADDR_ENABLE, 32'h0);

    // c_valid held for three cycles: a single claim side effect.
    bus_wr(ADDR_ENABLE, 32'h6);
    src[2:1] = 2'b11;
    cyc(4);
    c_valid = 1'b1; c_write = 1'b0; c_addr = ADDR_CLAIM;
    repeat (3) @(posedge c_clk);
    @(negedge c_clk);
    check("hold_rdata", c_rdata, 32'd2);
    c_valid = 1'b0;
    cyc(1);
    rd_chk("hold_inservice", ADDR_INSERVICE, 32'h2);
    check("hold_irq", 32'(irq_out), 32'd1);

    // Reset asserted during an access clears outputs immediately.
    c_valid = 1'b1; c_addr = ADDR_CLAIM;
    @(posedge c_clk);
    #1;
    c_rstb = 1'b0;
    #1;
    check("midrst_irq", 32'(irq_out), 32'd0);
    check("midrst_ready", 32'(c_ready), 32'd0);
    check("midrst_rdata", c_rdata, 32'd0);
    src = '0;
    @(negedge c_clk);
    c_valid = 1'b0;
    c_rstb = 1'b1;
    cyc(2);
    rd_chk("midrst_inservice", ADDR_INSERVICE, 32'h0);
    rd_chk("midrst_enable", ADDR_ENABLE, 32'h0);
    rd_chk("midrst_pending", ADDR_PENDING, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
